// File: rtl/pea_layer_scheduler.sv
// pea_layer_scheduler
// Walks a small programmable list of layer descriptors (conv/dense/pool) and,
// for each layer, steers the buffer/PE-array mux (comp_sel, aybz_azby), kicks
// the matching compute controller with a one-cycle pulse and waits for that
// controller's done before moving on. Every output is a flop.
//
// Handshake with the compute controllers: *_start is a single-cycle pulse
// issued in KICK, one cycle after comp_sel/aybz_azby have settled in LOAD.
// The controller answers with a single-cycle *_done pulse. A done is only
// sampled in RUN, and only the done of the controller selected by comp_sel
// counts; all other done pulses are ignored.
//
// A start that is accepted but runs no layers (count of zero, or a count
// larger than the list) still produces a done pulse two cycles after the
// start edge, without ever raising busy.
module pea_layer_scheduler #(
  parameter int MAX_LAYERS = 8,
  parameter int LW         = 3
) (
  input  logic          clk,
  input  logic          rst,
  // descriptor programming
  input  logic          cfg_we,
  input  logic [LW-1:0] cfg_addr,
  input  logic [1:0]    cfg_type,
  // run control
  input  logic [LW:0]   num_layers,
  input  logic          first_src_buf1,
  input  logic          start,
  input  logic          abort,
  // compute controller completions
  input  logic          conv_done,
  input  logic          dense_done,
  input  logic          pool_done,
  // compute controller kicks
  output logic          conv_start,
  output logic          dense_start,
  output logic          pool_start,
  // buffer/PEA mux steering
  output logic [2:0]    comp_sel,
  output logic [1:0]    aybz_azby,
  // status
  output logic [LW-1:0] layer_idx,
  output logic          busy,
  output logic          done,
  output logic          err,
  // FSM state for observation
  output logic [2:0]    dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_KICK   = 3'd2,
    S_RUN    = 3'd3,
    S_NEXT   = 3'd4,
    S_FINISH = 3'd5
  } state_t;

  localparam logic [1:0] T_INVALID = 2'b00;
  localparam logic [1:0] T_CONV    = 2'b01;
  localparam logic [1:0] T_DENSE   = 2'b10;
  localparam logic [1:0] T_POOL    = 2'b11;

  localparam logic [2:0] SEL_IDLE  = 3'b000;
  localparam logic [2:0] SEL_CONV  = 3'b001;
  localparam logic [2:0] SEL_DENSE = 3'b010;
  localparam logic [2:0] SEL_POOL  = 3'b011;

  // Ping-pong select driven whenever no layer is being set up or computed.
  localparam logic [1:0] AB_REST   = 2'b01;

  localparam logic [LW:0] MAX_CNT  = (LW+1)'(MAX_LAYERS);

  state_t        state;
  logic [1:0]    desc [MAX_LAYERS];
  // One bit wider than a descriptor index so it can reach the layer count.
  logic [LW:0]   idx;
  logic [LW:0]   num_layers_q;
  logic          src_buf1;

  logic [1:0]    nxt_type;
  logic          run_match;

  // Mux select for a layer type: dense uses the swapped pairing, conv and
  // pool share the direct pairing; the low bit follows the source buffer.
  function automatic logic [1:0] ab_sel(input logic [1:0] t, input logic s);
    return {(t == T_DENSE), s};
  endfunction

  // Descriptor list: written only while no run is in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MAX_LAYERS; i++) desc[i] <= T_INVALID;
    end else if (cfg_we && !busy) begin
      desc[cfg_addr] <= cfg_type;
    end
  end

  // Descriptor about to be loaded: entry 0 when leaving IDLE, otherwise the
  // already-advanced index when leaving NEXT.
  always_comb begin
    nxt_type = desc[(state == S_IDLE) ? LW'(0) : idx[LW-1:0]];
  end

  // Completion from the controller that is actually selected.
  always_comb begin
    run_match = 1'b0;
    case (comp_sel)
      SEL_CONV:  run_match = conv_done;
      SEL_DENSE: run_match = dense_done;
      SEL_POOL:  run_match = pool_done;
      default:   run_match = 1'b0;
    endcase
  end

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      comp_sel     <= SEL_IDLE;
      aybz_azby    <= AB_REST;
      conv_start   <= 1'b0;
      dense_start  <= 1'b0;
      pool_start   <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      idx          <= '0;
      num_layers_q <= '0;
      src_buf1     <= 1'b0;
    end else begin
      // Kicks and done are single-cycle pulses.
      conv_start  <= 1'b0;
      dense_start <= 1'b0;
      pool_start  <= 1'b0;
      done        <= 1'b0;

      if (abort && (state != S_IDLE)) begin
        // Abort overrides every transition; err keeps its value.
        state     <= S_IDLE;
        comp_sel  <= SEL_IDLE;
        aybz_azby <= AB_REST;
        busy      <= 1'b0;
        idx       <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            // A start in the same cycle as abort is dropped.
            if (start && !abort) begin
              idx          <= '0;
              num_layers_q <= num_layers;
              src_buf1     <= first_src_buf1;
              err          <= 1'b0;
              if (num_layers == '0) begin
                state <= S_FINISH;
              end else if (num_layers > MAX_CNT) begin
                state <= S_FINISH;
                err   <= 1'b1;
              end else begin
                state     <= S_LOAD;
                busy      <= 1'b1;
                comp_sel  <= {1'b0, nxt_type};
                aybz_azby <= ab_sel(nxt_type, first_src_buf1);
              end
            end
          end

          S_LOAD: begin
            // comp_sel already holds the descriptor type; 000 means invalid.
            if (comp_sel == SEL_IDLE) begin
              state     <= S_FINISH;
              err       <= 1'b1;
              done      <= 1'b1;
              busy      <= 1'b0;
              aybz_azby <= AB_REST;
            end else begin
              state       <= S_KICK;
              conv_start  <= (comp_sel == SEL_CONV);
              dense_start <= (comp_sel == SEL_DENSE);
              pool_start  <= (comp_sel == SEL_POOL);
            end
          end

          S_KICK: begin
            state <= S_RUN;
          end

          S_RUN: begin
            if (run_match) begin
              state     <= S_NEXT;
              comp_sel  <= SEL_IDLE;
              aybz_azby <= AB_REST;
              src_buf1  <= ~src_buf1;
              idx       <= idx + 1'b1;
            end
          end

          S_NEXT: begin
            // idx has already advanced to the following layer.
            if (idx < num_layers_q) begin
              state     <= S_LOAD;
              comp_sel  <= {1'b0, nxt_type};
              aybz_azby <= ab_sel(nxt_type, src_buf1);
            end else begin
              state <= S_FINISH;
              done  <= 1'b1;
              busy  <= 1'b0;
            end
          end

          S_FINISH: begin
            // Entered with done already high after a real run; a run with no
            // layers enters with done low and raises it one cycle later.
            if (done) begin
              state <= S_IDLE;
            end else begin
              done <= 1'b1;
            end
          end

          default: begin
            state     <= S_IDLE;
            comp_sel  <= SEL_IDLE;
            aybz_azby <= AB_REST;
            busy      <= 1'b0;
          end
        endcase
      end
    end
  end

  assign layer_idx = idx[LW-1:0];
  assign dbg_state = state;

endmodule

// File: tb/tb_pea_layer_scheduler.sv
// Directed bench for pea_layer_scheduler. An auto-responder plays the compute
// controllers (done five cycles after each kick); manual done inputs cover
// the wrong-source and early-done cases.
module tb_pea_layer_scheduler;

  localparam int LW = 3;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD   = 3'd1;
  localparam logic [2:0] ST_KICK   = 3'd2;
  localparam logic [2:0] ST_RUN    = 3'd3;
  localparam logic [2:0] ST_NEXT   = 3'd4;
  localparam logic [2:0] ST_FINISH = 3'd5;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_we;
  logic [LW-1:0] cfg_addr;
  logic [1:0]    cfg_type;
  logic [LW:0]   num_layers;
  logic          first_src_buf1;
  logic          start;
  logic          abort;
  logic          conv_done, dense_done, pool_done;
  logic          conv_start, dense_start, pool_start;
  logic [2:0]    comp_sel;
  logic [1:0]    aybz_azby;
  logic [LW-1:0] layer_idx;
  logic          busy, done, err;
  logic [2:0]    dbg_state;

  // controller models
  logic          resp_en = 1'b1;
  logic          rsp_conv = 1'b0, rsp_dense = 1'b0, rsp_pool = 1'b0;
  logic          man_conv = 1'b0, man_dense = 1'b0, man_pool = 1'b0;
  int            rsp_cnt = 0;
  logic [1:0]    rsp_type = 2'b00;

  // scoreboard: expected {comp_sel, aybz_azby} at each kick, in order
  logic [4:0]    exp_q[$];
  int            total = 0;
  int            bad = 0;

  assign conv_done  = rsp_conv  | man_conv;
  assign dense_done = rsp_dense | man_dense;
  assign pool_done  = rsp_pool  | man_pool;

  pea_layer_scheduler #(.MAX_LAYERS(8), .LW(LW)) dut (
    .clk            (clk),
    .rst            (rst),
    .cfg_we         (cfg_we),
    .cfg_addr       (cfg_addr),
    .cfg_type       (cfg_type),
    .num_layers     (num_layers),
    .first_src_buf1 (first_src_buf1),
    .start          (start),
    .abort          (abort),
    .conv_done      (conv_done),
    .dense_done     (dense_done),
    .pool_done      (pool_done),
    .conv_start     (conv_start),
    .dense_start    (dense_start),
    .pool_start     (pool_start),
    .comp_sel       (comp_sel),
    .aybz_azby      (aybz_azby),
    .layer_idx      (layer_idx),
    .busy           (busy),
    .done           (done),
    .err            (err),
    .dbg_state      (dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  // auto-responder: done is driven in the fifth cycle after the kick cycle
  always @(negedge clk) begin
    rsp_conv  = 1'b0;
    rsp_dense = 1'b0;
    rsp_pool  = 1'b0;
    if (rsp_cnt != 0) begin
      rsp_cnt--;
      if (rsp_cnt == 1) begin
        case (rsp_type)
          2'b01:   rsp_conv  = 1'b1;
          2'b10:   rsp_dense = 1'b1;
          2'b11:   rsp_pool  = 1'b1;
          default: ;
        endcase
      end
    end
    if (resp_en && (conv_start || dense_start || pool_start)) begin
      rsp_cnt  = 6;
      rsp_type = {dense_start | pool_start, conv_start | pool_start};
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [LW-1:0] a, input logic [1:0] t);
    cfg_we   = 1'b1;
    cfg_addr = a;
    cfg_type = t;
    tick();
    cfg_we   = 1'b0;
  endtask

  // Presents start for one edge; returns in the first cycle after that edge.
  task automatic start_run(input logic [LW:0] n, input logic fsb);
    num_layers     = n;
    first_src_buf1 = fsb;
    start          = 1'b1;
    tick();
    start          = 1'b0;
  endtask

  // Follows a run from cycle 1 to its done pulse, checking each kick against
  // the expected queue and the cycle in which done appears.
  task automatic track_run(input string tag, input int exp_done_c,
                           input int exp_c, input int exp_p, input int exp_d);
    int c, done_c, nc, np, nd;
    logic [4:0] e;
    c = 1; done_c = -1; nc = 0; np = 0; nd = 0;
    while (c <= 80) begin
      if (conv_start)  nc++;
      if (pool_start)  np++;
      if (dense_start) nd++;
      if (conv_start || pool_start || dense_start) begin
        chk($sformatf("%s_kick_expected", tag), (exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk($sformatf("%s_sel_at_kick", tag), {comp_sel, aybz_azby}, e);
        end
      end
      if (done) begin
        done_c = c;
        break;
      end
      tick();
      c++;
    end
    chk($sformatf("%s_done_cycle", tag), done_c, exp_done_c);
    chk($sformatf("%s_busy_at_done", tag), busy, 0);
    chk($sformatf("%s_conv_kicks", tag), nc, exp_c);
    chk($sformatf("%s_pool_kicks", tag), np, exp_p);
    chk($sformatf("%s_dense_kicks", tag), nd, exp_d);
    chk($sformatf("%s_queue_left", tag), exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    int seen;
    rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_type = 2'b00;
    num_layers = '0; first_src_buf1 = 1'b0; start = 1'b0; abort = 1'b0;

    // reset values
    #3;
    chk("rst_comp_sel", comp_sel, 3'b000);
    chk("rst_aybz", aybz_azby, 2'b01);
    chk("rst_starts", {conv_start, dense_start, pool_start}, 3'b000);
    chk("rst_flags", {busy, done, err}, 3'b000);
    chk("rst_layer_idx", layer_idx, 0);
    chk("rst_state", dbg_state, ST_IDLE);
    tick();
    rst = 1'b0;
    tick();

    // conv -> pool -> dense, first source BUF1
    cfg_write(0, 2'b01);
    cfg_write(1, 2'b11);
    cfg_write(2, 2'b10);
    exp_q.push_back({3'b001, 2'b01});
    exp_q.push_back({3'b011, 2'b00});
    exp_q.push_back({3'b010, 2'b11});
    start_run(4'd3, 1'b1);
    chk("run3_load_state", dbg_state, ST_LOAD);
    chk("run3_load_busy", busy, 1);
    chk("run3_load_sel", {comp_sel, aybz_azby}, {3'b001, 2'b01});
    track_run("run3", 25, 1, 1, 1);
    tick();
    chk("run3_back_idle", dbg_state, ST_IDLE);

    // empty run
    start_run(4'd0, 1'b0);
    chk("empty_t1_busy_done", {busy, done}, 2'b00);
    tick();
    chk("empty_t2_done", {busy, done, err}, 3'b010);
    tick();
    chk("empty_t3_idle", {dbg_state, done}, {ST_IDLE, 1'b0});

    // oversized run
    start_run(4'd9, 1'b0);
    chk("over_t1_err_busy", {err, busy, done}, 3'b100);
    tick();
    chk("over_t2_done", {done, busy, conv_start, pool_start, dense_start}, 5'b10000);
    tick();

    // invalid descriptor at index 1
    cfg_write(1, 2'b00);
    exp_q.push_back({3'b001, 2'b00});
    start_run(4'd3, 1'b0);
    chk("bad_desc_err_cleared", err, 0);
    track_run("bad_desc", 10, 1, 0, 0);
    chk("bad_desc_err", err, 1);
    tick();

    // abort in RUN of layer 1
    cfg_write(1, 2'b11);
    start_run(4'd3, 1'b1);
    repeat (11) tick();
    chk("abort_pre_state", {dbg_state, layer_idx, comp_sel}, {ST_RUN, 3'd1, 3'b011});
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_state", dbg_state, ST_IDLE);
    chk("abort_outputs", {comp_sel, aybz_azby, busy, done}, {3'b000, 2'b01, 1'b0, 1'b0});
    chk("abort_err_kept", err, 0);
    seen = 0;
    repeat (3) begin
      tick();
      if (done || conv_start || pool_start || dense_start) seen++;
    end
    chk("abort_quiet", seen, 0);
    exp_q.push_back({3'b001, 2'b01});
    exp_q.push_back({3'b011, 2'b00});
    exp_q.push_back({3'b010, 2'b11});
    start_run(4'd3, 1'b1);
    chk("restart_layer0", {layer_idx, comp_sel, err}, {3'd0, 3'b001, 1'b0});
    track_run("restart", 25, 1, 1, 1);
    tick();

    // wrong-source done, early done in KICK, write while busy
    resp_en = 1'b0;
    start_run(4'd1, 1'b0);
    tick();
    chk("ws_kick", {dbg_state, conv_start}, {ST_KICK, 1'b1});
    man_conv = 1'b1;
    cfg_we = 1'b1; cfg_addr = 3'd2; cfg_type = 2'b01;
    tick();
    cfg_we = 1'b0;
    man_conv = 1'b0;
    chk("ws_kick_done_ignored", dbg_state, ST_RUN);
    man_dense = 1'b1;
    tick();
    man_dense = 1'b0;
    chk("ws_dense_ignored", {dbg_state, comp_sel}, {ST_RUN, 3'b001});
    man_conv = 1'b1;
    tick();
    man_conv = 1'b0;
    chk("ws_conv_advances", {dbg_state, comp_sel, aybz_azby}, {ST_NEXT, 3'b000, 2'b01});
    tick();
    chk("ws_done", {done, busy}, 2'b10);
    tick();
    resp_en = 1'b1;
    exp_q.push_back({3'b001, 2'b00});
    exp_q.push_back({3'b011, 2'b01});
    exp_q.push_back({3'b010, 2'b10});
    start_run(4'd3, 1'b0);
    track_run("readback", 25, 1, 1, 1);
    tick();

    // asynchronous reset during RUN of layer 1
    start_run(4'd3, 1'b1);
    repeat (11) tick();
    chk("arst_pre", {dbg_state, layer_idx}, {ST_RUN, 3'd1});
    #2;
    rst = 1'b1;
    #1;
    chk("arst_state", dbg_state, ST_IDLE);
    chk("arst_outputs", {comp_sel, aybz_azby, busy, done, err, layer_idx},
        {3'b000, 2'b01, 1'b0, 1'b0, 1'b0, 3'd0});
    chk("arst_starts", {conv_start, dense_start, pool_start}, 3'b000);
    tick();
    rst = 1'b0;
    repeat (4) tick();
    // descriptors were cleared by reset, so layer 0 is now invalid
    start_run(4'd1, 1'b0);
    chk("arst_desc_cleared", {dbg_state, comp_sel}, {ST_LOAD, 3'b000});
    tick();
    chk("arst_desc_err", {done, err}, 2'b11);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
